// File: rtl/sm_hex_scan.sv
// Multiplexed hex display scanner: one lit digit at a time with a prescaled
// dwell, frame-synchronous value updates and optional leading-zero blanking.
module sm_hex_scan #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic                  load,
    output logic                  busy,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     digit_mask,
    output logic [3:0]            digit,
    output logic [DIGITS-1:0]     anode_en,
    output logic                  blank,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    typedef logic [IW-1:0] idx_t;

    logic [PW-1:0]       pcnt;
    idx_t                idx;
    logic [4*DIGITS-1:0] pending;
    logic [4*DIGITS-1:0] display;
    logic                wrap;

    logic                tick;
    logic                last;
    logic                bnd;
    logic [3:0]          cur;
    logic                en;
    logic                lzrun;
    logic                dark_lz;
    logic                dark;

    assign tick = (pcnt == PW'(PRESCALE - 1));
    assign last = (idx == IW'(DIGITS - 1));
    assign bnd  = tick && last;

    // lzrun accumulates "all nibbles from the top down to i are zero"
    always_comb begin
        cur     = 4'h0;
        en      = 1'b0;
        lzrun   = 1'b1;
        dark_lz = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lzrun = lzrun && (display[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                cur     = display[4*i +: 4];
                en      = digit_mask[i];
                dark_lz = blank_lz && (i != 0) && lzrun;
            end
        end
        dark = !en || dark_lz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            idx        <= '0;
            pending    <= '0;
            display    <= '0;
            busy       <= 1'b0;
            wrap       <= 1'b0;
            frame_done <= 1'b0;
            digit      <= 4'h0;
            anode_en   <= '0;
            blank      <= 1'b1;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= last ? '0 : idx + 1'b1;
            end
            // A load landing on the boundary bypasses pending entirely
            if (load && bnd) begin
                display <= value_in;
                busy    <= 1'b0;
            end else if (load) begin
                pending <= value_in;
                busy    <= 1'b1;
            end else if (bnd && busy) begin
                display <= pending;
                busy    <= 1'b0;
            end
            // Delayed one extra stage so it lines up with idx 0 on the outputs
            wrap       <= bnd;
            frame_done <= wrap;
            digit      <= cur;
            anode_en   <= dark ? '0 : (DIGITS'(1) << idx);
            blank      <= dark;
        end
    end

endmodule

// File: tb/tb_sm_hex_scan.sv
// Scoreboard bench for sm_hex_scan with DIGITS=4, PRESCALE=4.
// A behavioural model predicts every output cycle; directed checks pin key values.
module tb_sm_hex_scan;

    localparam int D = 4;
    localparam int P = 4;
    localparam int F = D * P;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        busy;
    logic        blank_lz;
    logic [3:0]  digit_mask;
    logic [3:0]  digit;
    logic [3:0]  anode_en;
    logic        blank;
    logic        frame_done;

    always #5 clk = ~clk;

    sm_hex_scan #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .busy       (busy),
        .blank_lz   (blank_lz),
        .digit_mask (digit_mask),
        .digit      (digit),
        .anode_en   (anode_en),
        .blank      (blank),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] digit;
        logic [3:0] an;
        logic       blank;
        logic       fd;
        logic       busy;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    int          m_t;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic        m_busy;
    logic        m_wrap;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predict this edge's outputs, clock, then compare; load is a one-cycle pulse.
    task automatic step();
        exp_t e;
        int   ix;
        bit   tick;
        bit   bnd;
        bit   dark;
        if (rst) begin
            e      = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
            m_t    = 0;
            m_pend = '0;
            m_disp = '0;
            m_busy = 1'b0;
            m_wrap = 1'b0;
        end else begin
            ix   = (m_t / P) % D;
            tick = (m_t % P) == P - 1;
            bnd  = tick && (ix == D - 1);
            dark = !digit_mask[ix] ||
                   (blank_lz && ix > 0 && (m_disp >> (4 * ix)) == 16'h0);
            e.digit = 4'(m_disp >> (4 * ix));
            e.an    = dark ? 4'h0 : 4'(1 << ix);
            e.blank = dark;
            e.fd    = m_wrap;
            if (load && bnd) begin
                m_disp = value_in;
                m_busy = 1'b0;
            end else if (load) begin
                m_pend = value_in;
                m_busy = 1'b1;
            end else if (bnd && m_busy) begin
                m_disp = m_pend;
                m_busy = 1'b0;
            end
            e.busy = m_busy;
            m_wrap = bnd;
            m_t++;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("sb_digit", 32'(digit), 32'(e.digit));
        check("sb_anode", 32'(anode_en), 32'(e.an));
        check("sb_blank", 32'(blank), 32'(e.blank));
        check("sb_frame_done", 32'(frame_done), 32'(e.fd));
        check("sb_busy", 32'(busy), 32'(e.busy));
        load = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Stop just before the frame-boundary cycle
    task automatic to_boundary();
        while ((m_t % F) != F - 1) step();
    endtask

    task automatic to_phase(input int ph);
        while ((m_t % F) != ph) step();
    endtask

    int fd_cnt;

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        value_in   = '0;
        blank_lz   = 1'b0;
        digit_mask = 4'hF;
        m_t = 0; m_pend = '0; m_disp = '0; m_busy = 1'b0; m_wrap = 1'b0;

        steps(3);
        check("rst_anode", 32'(anode_en), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);

        // Plain scan: one-hot walk, frame_done once per frame
        rst = 1'b0;
        step();
        check("first_anode", 32'(anode_en), 32'h1);
        check("first_blank", 32'(blank), 32'h0);
        steps(3);
        step();
        check("scan_anode1", 32'(anode_en), 32'h2);
        fd_cnt = 0;
        for (int i = 0; i < 2 * F; i++) begin
            step();
            if (frame_done) fd_cnt++;
        end
        check("fd_per_2frames", 32'(fd_cnt), 32'd2);

        // Mid-frame load shows in the following frame only
        to_phase(5);
        value_in = 16'h1A2F;
        load = 1'b1;
        step();
        check("busy_after_load", 32'(busy), 32'h1);
        to_boundary();
        step();
        check("old_frame_digit", 32'(digit), 32'h0);
        check("busy_at_bnd", 32'(busy), 32'h0);
        step();
        check("new_d0", 32'(digit), 32'hF);
        check("new_fd", 32'(frame_done), 32'h1);
        check("new_an0", 32'(anode_en), 32'h1);
        steps(4);
        check("new_d1", 32'(digit), 32'h2);
        steps(4);
        check("new_d2", 32'(digit), 32'hA);
        steps(4);
        check("new_d3", 32'(digit), 32'h1);
        check("new_an3", 32'(anode_en), 32'h8);

        // Two loads in one frame: last wins
        to_phase(2);
        value_in = 16'h1111;
        load = 1'b1;
        step();
        steps(3);
        value_in = 16'h2222;
        load = 1'b1;
        step();
        to_boundary();
        step();
        check("busy_clr", 32'(busy), 32'h0);
        step();
        check("last_wins", 32'(digit), 32'h2);

        // Load on the boundary cycle goes straight to display
        to_boundary();
        value_in = 16'h5555;
        load = 1'b1;
        step();
        check("bnd_load_busy", 32'(busy), 32'h0);
        step();
        check("bnd_load_d0", 32'(digit), 32'h5);

        // Leading-zero blanking
        blank_lz = 1'b1;
        value_in = 16'h0030;
        load = 1'b1;
        step();
        to_boundary();
        steps(2);
        check("lz_d0", 32'(digit), 32'h0);
        check("lz_an0", 32'(anode_en), 32'h1);
        steps(4);
        check("lz_d1", 32'(digit), 32'h3);
        check("lz_an1", 32'(anode_en), 32'h2);
        steps(4);
        check("lz_an2", 32'(anode_en), 32'h0);
        check("lz_blank2", 32'(blank), 32'h1);
        steps(4);
        check("lz_an3", 32'(anode_en), 32'h0);
        check("lz_blank3", 32'(blank), 32'h1);

        value_in = 16'h0000;
        load = 1'b1;
        step();
        to_boundary();
        steps(2);
        check("zero_an0", 32'(anode_en), 32'h1);
        steps(4);
        check("zero_an1", 32'(anode_en), 32'h0);
        blank_lz = 1'b0;

        // Reset mid-frame at idx 2
        value_in = 16'h9876;
        load = 1'b1;
        step();
        to_boundary();
        steps(2);
        to_phase(9);
        rst = 1'b1;
        load = 1'b1;
        value_in = 16'hFFFF;
        step();
        check("midrst_an", 32'(anode_en), 32'h0);
        check("midrst_blank", 32'(blank), 32'h1);
        rst = 1'b0;
        step();
        check("rel_an", 32'(anode_en), 32'h1);
        check("rel_digit", 32'(digit), 32'h0);
        check("rel_busy", 32'(busy), 32'h0);
        fd_cnt = 0;
        for (int i = 0; i < F - 1; i++) begin
            step();
            if (frame_done) fd_cnt++;
        end
        check("no_fd_abort", 32'(fd_cnt), 32'd0);

        // Random loads, masks and blanking against the model
        for (int i = 0; i < 400; i++) begin
            load       = ($urandom_range(0, 9) == 0);
            value_in   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value_in[15:8] = 8'h00;
            blank_lz   = 1'($urandom);
            digit_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sm_hex_scan.md
SM_HEX_SCAN -- requirements
Module: sm_hex_scan

Interface
REQ-001 Parameter DIGITS, default 8: number of hex digits scanned, range 2..8.
REQ-002 Parameter PRESCALE, default 1000: clock cycles each digit stays active, minimum 2.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port value_in, input, 4*DIGITS: value to display; nibble i is digit i, and digit 0 is the least-significant and rightmost digit.
REQ-006 Port load, input, 1: one-cycle request to capture value_in.
REQ-007 Port busy, output, 1: high while a captured value waits for the frame boundary.
REQ-008 Port blank_lz, input, 1: enables leading-zero blanking.
REQ-009 Port digit_mask, input, DIGITS: a 1 enables the digit, a 0 forces it dark.
REQ-010 Port digit, output, 4: nibble presented to the downstream hex-to-seven-segment decoder.
REQ-011 Port anode_en, output, DIGITS: one-hot, active-high enable of the currently lit digit; all zeros means dark.
REQ-012 Port blank, output, 1: high when the current digit slot is dark.
REQ-013 Port frame_done, output, 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Function
REQ-014 Prescaler pcnt counts 0..PRESCALE-1 and then wraps to 0; tick is true when pcnt == PRESCALE-1.
REQ-015 Index idx advances by 1 on tick and wraps from DIGITS-1 to 0; idx holds when there is no tick.
REQ-016 Frame boundary is the cycle in which tick is true and idx == DIGITS-1.
REQ-017 On load with busy low: value_in is captured into the pending register and busy is set on the next edge.
REQ-018 On load with busy high: value_in overwrites the pending register, so the last request wins.
REQ-019 At the frame boundary with busy high: the pending register is copied into the display register and busy is cleared.
REQ-020 If load and the frame boundary coincide: value_in is written directly into the display register, busy ends low, and any older pending value is discarded.
REQ-021 Captured and displayed values are never torn, so a frame always shows a single captured value.
REQ-022 Leading-zero blanking: when blank_lz=1, digit i (i>0) is dark if display nibbles DIGITS-1 down to i are all zero.
REQ-023 Digit 0 is never blanked by the leading-zero rule.
REQ-024 Digit slot idx is dark if digit_mask[idx]=0 or it is leading-zero blanked.
REQ-025 Outputs are registered with one cycle of latency; from the state at edge n they are:
  - digit = display nibble[idx]
  - anode_en = one-hot(idx), or zero when the slot is dark
  - blank = dark
REQ-026 When the slot is dark, digit still carries the nibble value; only anode_en and blank mark the slot as dark.
REQ-027 frame_done is registered and is high in the cycle after the frame boundary, concurrent with idx = 0 appearing on the outputs.
REQ-028 blank_lz and digit_mask are sampled every cycle, not latched per frame.
REQ-029 All counter and index arithmetic is unsigned; idx width is clog2(DIGITS), with a minimum of 1 bit.

Reset
REQ-030 While rst=1, on each edge:
  - pcnt=0, idx=0
  - pending and display registers cleared to 0
  - busy=0, digit=0, anode_en=0, blank=1, frame_done=0
REQ-031 rst has priority over load and tick.
REQ-032 A load pulse coincident with rst is dropped.
REQ-033 On the first edge after rst falls, outputs show digit 0 of the cleared display register: anode_en bit 0 set and blank=0 when digit_mask[0]=1.
REQ-034 A reset asserted mid-frame abandons the frame without pulsing frame_done.

Verification (DIGITS=4, PRESCALE=4)
REQ-035 Release reset, mask=4'hF, blank_lz=0.
  - Required: anode_en steps 0001, 0010, 0100, 1000 with each step held 4 cycles.
  - Required: frame_done pulses once every 16 cycles, concurrent with anode_en returning to 0001.
REQ-036 load with value_in=16'h1A2F mid-frame.
  - Required: busy=1 until the frame boundary.
  - Required: the next frame shows digit F, 2, A, 1 for idx 0..3.
  - Required: the current frame keeps the old value throughout.
REQ-037 Two loads (16'h1111, then 16'h2222) within one frame.
  - Required: only 16'h2222 is displayed.
  - Required: busy clears at the boundary.
REQ-038 load coincides with the frame boundary.
  - Required: the value appears in the frame starting the next cycle.
  - Required: busy stays 0.
REQ-039 value 16'h0030, blank_lz=1.
  - Required: idx 3 is dark (anode_en=0, blank=1) and idx 2 is dark.
  - Required: idx 1 shows 3 and idx 0 shows 0.
  - Required: with value 16'h0000, only idx 0 lights.
REQ-040 rst pulsed during idx=2.
  - Required: the next edge gives anode_en=0 and blank=1.
  - Required: after release, the scan restarts at idx 0 showing 0.
  - Required: no frame_done pulse occurs for the aborted frame.
